// File: rtl/param_datapath.sv
// param_datapath: accumulator datapath steered cycle-by-cycle by the control unit.
// It holds AC, R[NREG], {V,C,N,Z} flags, IR, AH/AL, PC, MDA and an optional return stack.
// Optional feature macro: RET_STACK_EN builds the hardware return-address stack.
// Ports: clk/reset (async, active-high); load enables ir_ld/ah_ld/al_ld/acc_ld/r_ld/
//   flags_ld/pc_ld/mda_ld; mux selects acc_sel/srcb_sel/pc_sel/adr_sel; alu_op; r_sel;
//   push/pop; memdata in; address/writedata/zero combinational; instr/flags/stk_err registered.
module param_datapath #(
  parameter int DW     = 8,
  parameter int NREG   = 4,
  parameter int SDEPTH = 4,
  localparam int AW    = 2 * DW,
  localparam int RW    = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ir_ld,
  input  logic          ah_ld,
  input  logic          al_ld,
  input  logic          acc_ld,
  input  logic [1:0]    acc_sel,
  input  logic          r_ld,
  input  logic [RW-1:0] r_sel,
  input  logic          srcb_sel,
  input  logic [3:0]    alu_op,
  input  logic          flags_ld,
  input  logic          pc_ld,
  input  logic [1:0]    pc_sel,
  input  logic          mda_ld,
  input  logic          adr_sel,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] memdata,
  output logic [AW-1:0] address,
  output logic [DW-1:0] writedata,
  output logic [DW-1:0] instr,
  output logic          zero,
  output logic [3:0]    flags,
  output logic          stk_err
);

  logic [DW-1:0] ac, ah, al, ir;
  logic [DW-1:0] rf [NREG];
  logic [AW-1:0] pc, mda, pc_inc, pc_next, stk_top;
  logic [DW-1:0] alu_b, alu_res, ac_next;
  logic [DW:0]   ext;
  logic          c_out, v_out, cin;

  assign cin    = flags[2];
  assign alu_b  = srcb_sel ? DW'(1) : rf[r_sel];
  assign pc_inc = pc + AW'(1);

  // ALU. ext carries one extra bit so bit DW is the carry (add) or borrow (sub).
  always_comb begin
    alu_res = ac;
    ext     = '0;
    c_out   = 1'b0;
    v_out   = 1'b0;
    case (alu_op)
      4'd1, 4'd8: begin
        ext     = {1'b0, ac} + {1'b0, alu_b} + {{DW{1'b0}}, (alu_op == 4'd8) & cin};
        alu_res = ext[DW-1:0];
        c_out   = ext[DW];
        v_out   = (ac[DW-1] == alu_b[DW-1]) && (alu_res[DW-1] != ac[DW-1]);
      end
      4'd2, 4'd9: begin
        ext     = {1'b0, ac} - {1'b0, alu_b} - {{DW{1'b0}}, (alu_op == 4'd9) & cin};
        alu_res = ext[DW-1:0];
        c_out   = ext[DW];
        v_out   = (ac[DW-1] != alu_b[DW-1]) && (alu_res[DW-1] != ac[DW-1]);
      end
      4'd3:  alu_res = '0;
      4'd4:  alu_res = ac & alu_b;
      4'd5:  alu_res = ac | alu_b;
      4'd6:  alu_res = ac ^ alu_b;
      4'd7:  alu_res = ~ac;
      4'd10: begin
        alu_res = {ac[DW-2:0], 1'b0};
        c_out   = ac[DW-1];
      end
      4'd11: begin
        alu_res = {1'b0, ac[DW-1:1]};
        c_out   = ac[0];
      end
      default: alu_res = ac;
    endcase
  end

  assign writedata = alu_res;
  assign zero      = (alu_res == '0);
  assign address   = adr_sel ? mda : pc;
  assign instr     = ir;

  always_comb begin
    case (acc_sel)
      2'd0:    ac_next = alu_res;
      2'd1:    ac_next = memdata;
      2'd2:    ac_next = rf[r_sel];
      default: ac_next = ac;
    endcase
  end

  always_comb begin
    case (pc_sel)
      2'd0:    pc_next = pc;
      2'd1:    pc_next = pc_inc;
      2'd2:    pc_next = {ah, al};
      default: pc_next = stk_top;
    endcase
  end

  // Register writes use pre-edge AC and R values, so r_ld with acc_sel=2 swaps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ac    <= '0;
      ah    <= '0;
      al    <= '0;
      ir    <= '0;
      pc    <= '0;
      mda   <= '0;
      flags <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (ir_ld)    ir    <= memdata;
      if (ah_ld)    ah    <= memdata;
      if (al_ld)    al    <= memdata;
      if (acc_ld)   ac    <= ac_next;
      if (r_ld)     rf[r_sel] <= ac;
      if (flags_ld) flags <= {v_out, c_out, alu_res[DW-1], (alu_res == '0)};
      if (pc_ld)    pc    <= pc_next;
      if (mda_ld)   mda   <= {ah, al};
    end
  end

`ifdef RET_STACK_EN
  localparam int SPW = $clog2(SDEPTH + 1);

  logic [SPW-1:0] sp, sp_nxt, wr_idx;
  logic [AW-1:0]  stk [SDEPTH];
  logic           empty, full, wr_en, err_set, err_q;

  assign empty = (sp == '0);
  assign full  = (sp == SPW'(SDEPTH));

  // Top of stack is stack[sp-1]; an empty stack reads as 0.
  always_comb begin
    stk_top = '0;
    for (int i = 0; i < SDEPTH; i++)
      if (sp == SPW'(i + 1)) stk_top = stk[i];
  end

  // push+pop replaces the top in place; on an empty stack it degrades to a push.
  always_comb begin
    sp_nxt  = sp;
    wr_en   = 1'b0;
    wr_idx  = sp;
    err_set = 1'b0;
    if (push && pop) begin
      wr_en = 1'b1;
      if (empty) sp_nxt = sp + SPW'(1);
      else       wr_idx = sp - SPW'(1);
    end else if (push) begin
      if (full) err_set = 1'b1;
      else begin
        wr_en  = 1'b1;
        sp_nxt = sp + SPW'(1);
      end
    end else if (pop) begin
      if (empty) err_set = 1'b1;
      else       sp_nxt  = sp - SPW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp    <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < SDEPTH; i++) stk[i] <= '0;
    end else begin
      sp <= sp_nxt;
      if (err_set) err_q <= 1'b1;
      for (int i = 0; i < SDEPTH; i++)
        if (wr_en && (wr_idx == SPW'(i))) stk[i] <= pc_inc;
    end
  end

  assign stk_err = err_q;
`else
  // Without the stack, pc_sel=3 falls back to PC+1 and push/pop do nothing.
  logic                         unused_stk;
  logic [$clog2(SDEPTH+1)-1:0]  unused_sp;
  assign unused_stk = push ^ pop;
  assign unused_sp  = '0;
  assign stk_top    = pc_inc;
  assign stk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_param_datapath.sv
module tb_param_datapath;

  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk, reset;
  logic          ir_ld, ah_ld, al_ld, acc_ld, r_ld, srcb_sel, flags_ld, pc_ld, mda_ld, adr_sel;
  logic          push, pop, zero, stk_err;
  logic [1:0]    acc_sel, pc_sel, r_sel;
  logic [3:0]    alu_op, flags;
  logic [DW-1:0] memdata, writedata, instr;
  logic [AW-1:0] address;

  param_datapath #(.DW(DW), .NREG(4), .SDEPTH(4)) dut (
    .clk(clk), .reset(reset), .ir_ld(ir_ld), .ah_ld(ah_ld), .al_ld(al_ld),
    .acc_ld(acc_ld), .acc_sel(acc_sel), .r_ld(r_ld), .r_sel(r_sel),
    .srcb_sel(srcb_sel), .alu_op(alu_op), .flags_ld(flags_ld), .pc_ld(pc_ld),
    .pc_sel(pc_sel), .mda_ld(mda_ld), .adr_sel(adr_sel), .push(push), .pop(pop),
    .memdata(memdata), .address(address), .writedata(writedata), .instr(instr),
    .zero(zero), .flags(flags), .stk_err(stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic expect_val(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [15:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    ir_ld = 0; ah_ld = 0; al_ld = 0; acc_ld = 0; acc_sel = 2'd3; r_ld = 0; r_sel = 0;
    srcb_sel = 0; alu_op = 0; flags_ld = 0; pc_ld = 0; pc_sel = 0; mda_ld = 0;
    adr_sel = 0; push = 0; pop = 0; memdata = 0;
  endtask

  // Controls are applied one time unit after an edge and outputs are read mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic ld_ac(input logic [7:0] v);
    memdata = v; acc_ld = 1; acc_sel = 2'd1; tick();
  endtask

  task automatic wr_r(input logic [1:0] idx, input logic [7:0] v);
    ld_ac(v);
    r_ld = 1; r_sel = idx; tick();
  endtask

  task automatic set_pc(input logic [15:0] v);
    memdata = v[15:8]; ah_ld = 1; tick();
    memdata = v[7:0];  al_ld = 1; tick();
    pc_ld = 1; pc_sel = 2'd2; tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    expect_val("rst_address", 16'h0000); chk(address);
    expect_val("rst_instr",   16'h0000); chk({8'h00, instr});
    expect_val("rst_flags",   16'h0000); chk({12'h000, flags});
    expect_val("rst_stk_err", 16'h0000); chk({15'h0000, stk_err});
    #10 reset = 1'b0;
    tick();

    // Build up state, then reset in the middle of a cycle.
    set_pc(16'h1234);
    expect_val("jump_address", 16'h1234); chk(address);
    ld_ac(8'h55);
    memdata = 8'hA7; ir_ld = 1; tick();
    expect_val("ir_load", 16'h00A7); chk({8'h00, instr});
    alu_op = 4'd7; flags_ld = 1;
    #1 expect_val("not_result", 16'h00AA); chk({8'h00, writedata});
    tick();
    expect_val("not_flags", 16'h0002); chk({12'h000, flags});
    reset = 1'b1;
    #1;
    expect_val("midrst_address", 16'h0000); chk(address);
    expect_val("midrst_flags",   16'h0000); chk({12'h000, flags});
    expect_val("midrst_instr",   16'h0000); chk({8'h00, instr});
    tick();
    expect_val("midrst_ac", 16'h0000); chk({8'h00, writedata});
    reset = 1'b0;
    #1;

    // Signed overflow on add, then borrow on sub.
    wr_r(2'd1, 8'h01);
    ld_ac(8'h7F);
    alu_op = 4'd1; srcb_sel = 0; r_sel = 2'd1; flags_ld = 1;
    #1 expect_val("add_result", 16'h0080); chk({8'h00, writedata});
    tick();
    expect_val("add_flags", 16'h000A); chk({12'h000, flags});
    ld_ac(8'h00);
    alu_op = 4'd2; srcb_sel = 1; flags_ld = 1;
    #1 expect_val("sub_result", 16'h00FF); chk({8'h00, writedata});
    tick();
    expect_val("sub_flags", 16'h0006); chk({12'h000, flags});

    // adc consumes C=1 from the sub above; shr then shifts out a 1.
    ld_ac(8'hFF);
    alu_op = 4'd8; srcb_sel = 1; flags_ld = 1; acc_ld = 1; acc_sel = 2'd0;
    #1 expect_val("adc_result", 16'h0001); chk({8'h00, writedata});
    tick();
    expect_val("adc_flags", 16'h0004); chk({12'h000, flags});
    expect_val("adc_ac", 16'h0001); chk({8'h00, writedata});
    alu_op = 4'd11; flags_ld = 1;
    #1 expect_val("shr_result", 16'h0000); chk({8'h00, writedata});
    expect_val("shr_zero", 16'h0001); chk({15'h0000, zero});
    tick();
    expect_val("shr_flags", 16'h0005); chk({12'h000, flags});

    // sbc with C=1: 0x10 - 0x01 - 1 = 0x0E, no borrow.
    ld_ac(8'h10);
    alu_op = 4'd9; srcb_sel = 1; flags_ld = 1;
    #1 expect_val("sbc_result", 16'h000E); chk({8'h00, writedata});
    tick();
    expect_val("sbc_flags", 16'h0000); chk({12'h000, flags});

    ld_ac(8'h80);
    alu_op = 4'd2; srcb_sel = 1; flags_ld = 1;
    #1 expect_val("subv_result", 16'h007F); chk({8'h00, writedata});
    tick();
    expect_val("subv_flags", 16'h0008); chk({12'h000, flags});

    // Logic ops on 0xA5 with constant 1.
    ld_ac(8'hA5);
    srcb_sel = 1;
    alu_op = 4'd10; flags_ld = 1;
    #1 expect_val("shl_result", 16'h004A); chk({8'h00, writedata});
    tick();
    expect_val("shl_flags", 16'h0004); chk({12'h000, flags});
    srcb_sel = 1; alu_op = 4'd4;
    #1 expect_val("and_result", 16'h0001); chk({8'h00, writedata});
    alu_op = 4'd5;
    #1 expect_val("or_result", 16'h00A5); chk({8'h00, writedata});
    alu_op = 4'd6;
    #1 expect_val("xor_result", 16'h00A4); chk({8'h00, writedata});
    alu_op = 4'd13;
    #1 expect_val("op13_pass", 16'h00A5); chk({8'h00, writedata});
    alu_op = 4'd3;
    #1 expect_val("clr_zero", 16'h0001); chk({15'h0000, zero});
    tick();

    // Swap AC with R[2] in one cycle.
    wr_r(2'd2, 8'h3C);
    ld_ac(8'hA5);
    r_ld = 1; acc_ld = 1; acc_sel = 2'd2; r_sel = 2'd2; tick();
    expect_val("swap_ac", 16'h003C); chk({8'h00, writedata});
    acc_ld = 1; acc_sel = 2'd2; r_sel = 2'd2; tick();
    expect_val("swap_r2", 16'h00A5); chk({8'h00, writedata});

    // MDA addressing and PC wrap.
    memdata = 8'hBE; ah_ld = 1; tick();
    memdata = 8'hEF; al_ld = 1; tick();
    mda_ld = 1; tick();
    adr_sel = 1;
    #1 expect_val("mda_address", 16'hBEEF); chk(address);
    tick();
    set_pc(16'hFFFF);
    pc_ld = 1; pc_sel = 2'd1; tick();
    expect_val("pc_wrap", 16'h0000); chk(address);

`ifdef RET_STACK_EN
    // Pop on empty stack.
    do_reset();
    set_pc(16'h0040);
    expect_val("pre_pop_err", 16'h0000); chk({15'h0000, stk_err});
    pop = 1; pc_ld = 1; pc_sel = 2'd3; tick();
    expect_val("empty_pop_pc", 16'h0000); chk(address);
    expect_val("empty_pop_err", 16'h0001); chk({15'h0000, stk_err});

    // Call and return.
    do_reset();
    expect_val("err_cleared", 16'h0000); chk({15'h0000, stk_err});
    set_pc(16'h0040);
    memdata = 8'h12; ah_ld = 1; tick();
    memdata = 8'h34; al_ld = 1; tick();
    pc_ld = 1; pc_sel = 2'd2; push = 1; tick();
    expect_val("call_pc", 16'h1234); chk(address);
    pc_ld = 1; pc_sel = 2'd1; tick();
    pc_ld = 1; pc_sel = 2'd3; pop = 1; tick();
    expect_val("ret_pc", 16'h0041); chk(address);
    pc_ld = 1; pc_sel = 2'd3; tick();
    expect_val("ret_sp0", 16'h0000); chk(address);
    expect_val("ret_err", 16'h0000); chk({15'h0000, stk_err});

    // Overflow: fifth push is dropped.
    do_reset();
    set_pc(16'h0040);
    for (int i = 0; i < 4; i++) begin
      push = 1; pc_ld = 1; pc_sel = 2'd1; tick();
    end
    expect_val("four_push_err", 16'h0000); chk({15'h0000, stk_err});
    push = 1; pc_ld = 1; pc_sel = 2'd1; tick();
    expect_val("fifth_push_err", 16'h0001); chk({15'h0000, stk_err});
    pop = 1; pc_ld = 1; pc_sel = 2'd3; tick();
    expect_val("full_top", 16'h0044); chk(address);
    push = 1; pop = 1; tick();
    pop = 1; pc_ld = 1; pc_sel = 2'd3; tick();
    expect_val("replace_top", 16'h0045); chk(address);
    pop = 1; pc_ld = 1; pc_sel = 2'd3; tick();
    expect_val("next_top", 16'h0042); chk(address);
    expect_val("err_sticky", 16'h0001); chk({15'h0000, stk_err});
`else
    do_reset();
    set_pc(16'h0040);
    push = 1; pc_ld = 1; pc_sel = 2'd3; tick();
    expect_val("nostk_sel3", 16'h0041); chk(address);
    pop = 1; pc_ld = 1; pc_sel = 2'd3; tick();
    expect_val("nostk_pop", 16'h0042); chk(address);
    expect_val("nostk_err", 16'h0000); chk({15'h0000, stk_err});
`endif

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/param_datapath.md
# param_datapath

Second-generation accumulator datapath: a DW-bit accumulator, NREG-entry general register file, registered 4-bit status flags (Z/N/C/V), AW=2·DW program/data addressing and an optional hardware return-address stack. It is steered cycle-by-cycle by the control unit. It sits between the control unit and the memory interface. All holding elements are edge-triggered registers with load enables; there are no transparent latches.

## Interface
- DW, 8: data width; AW = 2·DW is derived, not a parameter
- NREG, 4: general registers, power of two ≥ 2; RW = log2(NREG)
- SDEPTH, 4: return-stack entries, ≥ 1; used only when the stack is compiled in

- clk  in  1  clock
- reset  in  1  asynchronous, active-high; clears every register
- ir_ld, ah_ld, al_ld  in  1 each  load IR / AH / AL from memdata
- acc_ld  in  1  load AC from the AC mux
- acc_sel  in  2  AC mux: 0 ALU result, 1 memdata, 2 R[r_sel], 3 hold
- r_ld  in  1  write AC into R[r_sel]
- r_sel  in  RW  register index
- srcb_sel  in  1  ALU B operand: 0 R[r_sel], 1 constant 1
- alu_op  in  4  operation select
- flags_ld  in  1  capture ALU flags
- pc_ld  in  1  load PC from the PC mux
- pc_sel  in  2  PC mux: 0 PC, 1 PC+1, 2 {AH,AL}, 3 stack top
- mda_ld  in  1  load MDA with {AH,AL}
- adr_sel  in  1  address: 0 PC, 1 MDA
- push, pop  in  1 each  return-stack controls
- memdata  in  DW  memory read data
- address  out  AW  memory address (combinational)
- writedata  out  DW  ALU result (combinational)
- instr  out  DW  IR contents
- zero  out  1  combinational Z of the current ALU result
- flags  out  4  registered {V,C,N,Z}
- stk_err  out  1  sticky stack-fault flag

## Operation
- ALU: A = AC, B = srcb mux.
  - Ops: 0 pass A; 1 A+B; 2 A−B; 3 clear; 4 AND; 5 OR; 6 XOR; 7 NOT A; 8 A+B+C; 9 A−B−C; 10 shl; 11 shr (logical).
  - 12–15 behave as pass A.
  - Arithmetic is modulo 2^DW.
- Flags:
  - Z = (result==0).
  - N = result[DW−1].
  - C = carry-out for add and adc.
  - C = borrow for sub and sbc; borrow is 1 when the unsigned A < B (+C for sbc).
  - C = shifted-out bit for shl/shr; C = 0 for all other ops.
  - V = signed overflow for ops 1, 2, 8 and 9; V = 0 for all other ops.
- Register file: R[r_sel] is written from the pre-edge AC value. In the same cycle, acc_ld with acc_sel=2 reads the pre-edge R value (a swap is legal).
- PC: AW bits, wraps from all-ones to 0. PC+1 is always computed.
- Return stack:
  - push writes PC+1 (pre-edge PC) to stack[sp] and increments sp.
  - pop decrements sp.
  - The stack top is stack[sp−1], or 0 when the stack is empty.
  - pc_sel=3 with pop implements a return.
  - push and pop in the same cycle: top is replaced with PC+1; sp is unchanged. On an empty stack this acts as a plain push.
  - push when full (sp==SDEPTH): ignored, stk_err←1.
  - pop when empty: ignored, stk_err←1.
  - stk_err clears only on reset.

## Timing
- Registered outputs update on posedge clk: instr, flags, stk_err. Internal state also updates on posedge clk: AC, R[], AH, AL, PC, MDA, sp, stack.
- address, writedata and zero are combinational; they are valid in the same cycle as their controls change.
- Load latency: memdata→IR/AH/AL/AC in 1 cycle. A jump takes effect 1 cycle after pc_ld with pc_sel=2.
- Reset, including when asserted mid-instruction: immediately forces all registers, sp, stack entries, flags and stk_err to 0. Therefore address=0, instr=0 and flags=0.
- Disabled loads hold their value. Control combinations not listed have no side effects.

## Configuration
- RET_STACK_EN defined:
  - The return stack, push/pop and pc_sel=3 operate as described.
- RET_STACK_EN undefined:
  - No stack storage is built; push and pop are ignored.
  - pc_sel=3 behaves as pc_sel=1.
  - stk_err is tied to 0.

## Test plan
- Reset mid-run with PC=0x1234 and AC=0x55 -> next cycle address=0x0000, flags=0, instr=0.
- DW=8: AC=0x7F, R[1]=0x01, alu_op=1, flags_ld -> writedata=0x80, flags {V,C,N,Z}=1010; then AC=0x00, alu_op=2, B=1 -> 0xFF, flags=0110.
- Accumulate with adc: AC=0xFF plus constant 1 (C=1 from a prior op) -> 0x01, C=1; then shr of 0x01 -> 0x00, C=1, Z=1.
- Jump/call: AH=0x12, AL=0x34, pc_sel=2 with push at PC=0x0040 -> PC=0x1234; later pop with pc_sel=3 -> PC=0x0041, sp=0.
- Stack bounds, SDEPTH=4: five pushes -> fifth ignored, stk_err=1, stays 1; pop on empty after reset -> PC takes 0 via pc_sel=3, stk_err=1.
- Swap: AC=0xA5, R[2]=0x3C, r_ld with acc_ld and acc_sel=2, r_sel=2 -> AC=0x3C, R[2]=0xA5. Rebuild without RET_STACK_EN: pc_sel=3 -> PC+1, stk_err=0.
